// File: rtl/cnn_pkg.sv
// Shared helpers for the convolution datapath: safe bit-width sizing and
// window-geometry arithmetic used by the window generator and the layer controller.
package cnn_pkg;

  function automatic int clog2_safe(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int windows_per_frame(input int img_width, input int img_height,
                                           input int win_size, input int stride);
    return ((img_width - win_size) / stride + 1) * ((img_height - win_size) / stride + 1);
  endfunction

  // Coordinate of the last stride-aligned window anchor along one axis.
  function automatic int last_aligned(input int extent, input int win_size, input int stride);
    return win_size - 1 + ((extent - win_size) / stride) * stride;
  endfunction

endpackage

// File: rtl/window_line_buffer_if.sv
// Pixel-stream input and parallel-window output of the sliding-window generator.
interface window_line_buffer_if
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int WIN_SIZE   = 3
) ();

  localparam int CW = clog2_safe(IMG_WIDTH);
  localparam int RW = clog2_safe(IMG_HEIGHT);

  logic                                    sof;
  logic [DATA_WIDTH-1:0]                   pixel_in;
  logic                                    pixel_valid;
  logic [DATA_WIDTH*WIN_SIZE*WIN_SIZE-1:0] window_out;
  logic                                    window_valid;
  logic                                    frame_done;
  logic [RW-1:0]                           row_idx;
  logic [CW-1:0]                           col_idx;

  modport master (
    output sof, pixel_in, pixel_valid,
    input  window_out, window_valid, frame_done, row_idx, col_idx
  );

  modport slave (
    input  sof, pixel_in, pixel_valid,
    output window_out, window_valid, frame_done, row_idx, col_idx
  );

endinterface

// File: rtl/line_delay.sv
// Full-row pixel delay: circular RAM of DEPTH entries sharing one wrapping
// read/write pointer, so q is the sample written DEPTH enabled cycles ago.
module line_delay
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 28
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int PW = clog2_safe(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         ptr_q, ptr_d;

  // NOTE: every signal written here gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (en) begin
      mem_d[ptr_q] = d;
      ptr_d        = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // NOTE: the storage is cleared by reset because stale rows must read back as zero; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
      ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      mem_q <= mem_d;
      ptr_q <= ptr_d;
    end
  end

  assign q = mem_q[ptr_q];

endmodule

// File: rtl/window_line_buffer.sv
// Sliding WIN_SIZE x WIN_SIZE window generator over a raster pixel stream, with
// WIN_SIZE-1 row delays, stride decimation and frame-position tracking.
module window_line_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28,
  parameter int WIN_SIZE   = 3,
  parameter int STRIDE     = 1
) (
  input  logic               clock,
  input  logic               reset,
  window_line_buffer_if.slave bus
);

  localparam int CW       = clog2_safe(IMG_WIDTH);
  localparam int RW       = clog2_safe(IMG_HEIGHT);
  localparam int PW       = clog2_safe(STRIDE);
  localparam int WW       = DATA_WIDTH * WIN_SIZE * WIN_SIZE;
  localparam int LAST_COL = last_aligned(IMG_WIDTH, WIN_SIZE, STRIDE);
  localparam int LAST_ROW = last_aligned(IMG_HEIGHT, WIN_SIZE, STRIDE);

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  pixel_t ld_in  [WIN_SIZE-1];
  pixel_t ld_out [WIN_SIZE-1];

  // The newest row feeds the top delay; each delay output feeds the next-older one.
  for (genvar k = 0; k < WIN_SIZE - 1; k++) begin : g_line
    if (k == WIN_SIZE - 2) begin : g_newest
      assign ld_in[k] = bus.pixel_in;
    end else begin : g_older
      assign ld_in[k] = ld_out[k+1];
    end
    line_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_line_delay (
      .clock (clock),
      .reset (reset),
      .en    (bus.pixel_valid),
      .d     (ld_in[k]),
      .q     (ld_out[k])
    );
  end

  pixel_t        shift_q [WIN_SIZE][WIN_SIZE];
  pixel_t        shift_d [WIN_SIZE][WIN_SIZE];
  logic [WW-1:0] window_q, window_d;
  logic          window_valid_q, window_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [CW-1:0] col_q, col_d, col_idx_q, col_idx_d;
  logic [RW-1:0] row_q, row_d, row_idx_q, row_idx_d;
  logic [PW-1:0] col_phase_q, col_phase_d, row_phase_q, row_phase_d;

  logic [CW-1:0] eff_col;
  logic [RW-1:0] eff_row;
  logic [PW-1:0] cur_col_phase, cur_row_phase;
  logic          col_active, row_active, row_end;

  // sof overrides the running counters so this pixel is treated as (0,0).
  assign eff_col       = bus.sof ? '0 : col_q;
  assign eff_row       = bus.sof ? '0 : row_q;
  assign col_active    = (eff_col >= CW'(WIN_SIZE - 1));
  assign row_active    = (eff_row >= RW'(WIN_SIZE - 1));
  assign row_end       = (eff_col == CW'(IMG_WIDTH - 1));
  assign cur_col_phase = (eff_col == CW'(WIN_SIZE - 1)) ? '0 : col_phase_q;
  assign cur_row_phase = (eff_row == RW'(WIN_SIZE - 1)) ? '0 : row_phase_q;

  always_comb begin
    shift_d        = shift_q;
    window_d       = window_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    col_d          = col_q;
    row_d          = row_q;
    col_idx_d      = col_idx_q;
    row_idx_d      = row_idx_q;
    col_phase_d    = col_phase_q;
    row_phase_d    = row_phase_q;

    if (bus.pixel_valid) begin
      for (int r = 0; r < WIN_SIZE; r++) begin
        for (int c = 0; c < WIN_SIZE - 1; c++) begin
          shift_d[r][c] = shift_q[r][c+1];
        end
      end
      for (int r = 0; r < WIN_SIZE - 1; r++) begin
        shift_d[r][WIN_SIZE-1] = ld_out[r];
      end
      shift_d[WIN_SIZE-1][WIN_SIZE-1] = bus.pixel_in;

      if (row_end) begin
        col_d = '0;
        row_d = (eff_row == RW'(IMG_HEIGHT - 1)) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
        row_d = eff_row;
      end

      if (col_active) begin
        col_phase_d = (cur_col_phase == PW'(STRIDE - 1)) ? '0 : cur_col_phase + 1'b1;
      end
      if (row_active && row_end) begin
        row_phase_d = (cur_row_phase == PW'(STRIDE - 1)) ? '0 : cur_row_phase + 1'b1;
      end

      // Columns left over from the previous row are excluded by col_active.
      if (col_active && row_active && cur_col_phase == '0 && cur_row_phase == '0) begin
        window_valid_d = 1'b1;
        frame_done_d   = (eff_col == CW'(LAST_COL)) && (eff_row == RW'(LAST_ROW));
        col_idx_d      = eff_col;
        row_idx_d      = eff_row;
        for (int r = 0; r < WIN_SIZE; r++) begin
          for (int c = 0; c < WIN_SIZE; c++) begin
            window_d[(r*WIN_SIZE+c)*DATA_WIDTH +: DATA_WIDTH] = shift_d[r][c];
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_q        <= '{default: '0};
      window_q       <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      col_q          <= '0;
      row_q          <= '0;
      col_idx_q      <= '0;
      row_idx_q      <= '0;
      col_phase_q    <= '0;
      row_phase_q    <= '0;
    end else begin
      shift_q        <= shift_d;
      window_q       <= window_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
      col_q          <= col_d;
      row_q          <= row_d;
      col_idx_q      <= col_idx_d;
      row_idx_q      <= row_idx_d;
      col_phase_q    <= col_phase_d;
      row_phase_q    <= row_phase_d;
    end
  end

  assign bus.window_out   = window_q;
  assign bus.window_valid = window_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.row_idx      = row_idx_q;
  assign bus.col_idx      = col_idx_q;

endmodule
